// File: rtl/key_pkg.sv
// Shared types and constants for the keypad debounce / auto-repeat stage.
package key_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DEB_P,
        HELD,
        REPEAT,
        DEB_R
    } key_state_t;

    localparam logic [4:0] KEY_NULL = 5'd0;
    localparam logic [4:0] KEY_MAX  = 5'd16;

endpackage

// File: rtl/key_event.sv
// Debounces the scanned key code and emits one-cycle press, auto-repeat and
// release events; every output comes straight from a register.
module key_event
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 640000,
    parameter int unsigned REPEAT_DELAY    = 16000000,
    parameter int unsigned REPEAT_PERIOD   = 3200000
) (
    input  logic       mclk,
    input  logic       rst,
    input  logic [4:0] key_code,
    output logic       ev_valid,
    output logic       ev_repeat,
    output logic       ev_release,
    output logic [4:0] ev_code,
    output logic       held
);

    localparam int unsigned MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int unsigned MAX_P  = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
    localparam int unsigned CNT_W  = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    // The sample that opens a debounce window counts as the first stable
    // sample, so the debounce terminal value is one lower than the repeat ones.
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

    key_state_t       r_state;
    key_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [4:0]       r_cand;
    logic [4:0]       w_cand_nxt;
    logic             r_ev_valid;
    logic             r_ev_repeat;
    logic             r_ev_release;
    logic [4:0]       r_ev_code;
    logic             r_held;
    logic             w_valid_nxt;
    logic             w_repeat_nxt;
    logic             w_release_nxt;
    logic [4:0]       w_code_nxt;
    logic             w_held_nxt;
    logic [4:0]       w_key;

    // Codes outside 1..16 are indistinguishable from "no key".
    assign w_key = (key_code != KEY_NULL && key_code <= KEY_MAX) ? key_code : KEY_NULL;

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_cand       <= KEY_NULL;
            r_ev_valid   <= 1'b0;
            r_ev_repeat  <= 1'b0;
            r_ev_release <= 1'b0;
            r_ev_code    <= KEY_NULL;
            r_held       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_cand       <= w_cand_nxt;
            r_ev_valid   <= w_valid_nxt;
            r_ev_repeat  <= w_repeat_nxt;
            r_ev_release <= w_release_nxt;
            r_ev_code    <= w_code_nxt;
            r_held       <= w_held_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_cand_nxt    = r_cand;
        w_valid_nxt   = 1'b0;
        w_repeat_nxt  = 1'b0;
        w_release_nxt = 1'b0;
        w_code_nxt    = r_ev_code;

        case (r_state)
            IDLE: begin
                if (w_key != KEY_NULL) begin
                    w_cand_nxt  = w_key;
                    w_cnt_nxt   = '0;
                    w_state_nxt = DEB_P;
                end
            end
            DEB_P: begin
                if (w_key == r_cand) begin
                    if (r_cnt == DEB_LAST) begin
                        w_valid_nxt = 1'b1;
                        w_code_nxt  = r_cand;
                        w_cnt_nxt   = '0;
                        w_state_nxt = HELD;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end else if (w_key == KEY_NULL) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_cand_nxt = w_key;
                    w_cnt_nxt  = '0;
                end
            end
            HELD, REPEAT: begin
                if (w_key == r_cand) begin
                    if (r_cnt == ((r_state == HELD) ? DLY_LAST : PER_LAST)) begin
                        w_valid_nxt  = 1'b1;
                        w_repeat_nxt = 1'b1;
                        w_code_nxt   = r_cand;
                        w_cnt_nxt    = '0;
                        w_state_nxt  = REPEAT;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end else begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = DEB_R;
                end
            end
            DEB_R: begin
                // A different key also counts as release; it is pressed afresh from IDLE.
                if (w_key != r_cand) begin
                    if (r_cnt == DEB_LAST) begin
                        w_release_nxt = 1'b1;
                        w_code_nxt    = r_cand;
                        w_cnt_nxt     = '0;
                        w_cand_nxt    = KEY_NULL;
                        w_state_nxt   = IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end else begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = HELD;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_cand_nxt  = KEY_NULL;
                w_state_nxt = IDLE;
            end
        endcase

        w_held_nxt = (w_state_nxt == HELD) || (w_state_nxt == REPEAT) || (w_state_nxt == DEB_R);
    end

    assign ev_valid   = r_ev_valid;
    assign ev_repeat  = r_ev_repeat;
    assign ev_release = r_ev_release;
    assign ev_code    = r_ev_code;
    assign held       = r_held;

endmodule

// File: tb/tb_key_event.sv
// Directed bench for key_event: a run-length event model checked every cycle,
// plus hand-computed event timings for each scenario.
module tb_key_event;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;
    localparam int K_PRESS = 1;
    localparam int K_REP   = 2;
    localparam int K_REL   = 3;

    logic       mclk = 1'b0;
    logic       rst;
    logic [4:0] key_code;
    logic       ev_valid;
    logic       ev_repeat;
    logic       ev_release;
    logic [4:0] ev_code;
    logic       held;

    key_event #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) u_dut (
        .mclk      (mclk),
        .rst       (rst),
        .key_code  (key_code),
        .ev_valid  (ev_valid),
        .ev_repeat (ev_repeat),
        .ev_release(ev_release),
        .ev_code   (ev_code),
        .held      (held)
    );

    always #5 mclk = ~mclk;

    // Model: counts consecutive samples rather than tracking controller states.
    int         cyc = 0;
    bit         m_held;
    logic [4:0] m_key;
    int         m_run, m_off, m_since, m_nrep;
    logic       exp_valid, exp_repeat, exp_release, exp_held;
    logic [4:0] exp_code;
    int         q_cyc[$];
    int         q_kind[$];
    logic [4:0] q_code[$];

    always @(posedge mclk or posedge rst) begin
        logic [4:0] s;
        if (rst) begin
            m_held = 1'b0; m_key = 5'd0;
            m_run = 0; m_off = 0; m_since = 0; m_nrep = 0;
            exp_valid = 1'b0; exp_repeat = 1'b0; exp_release = 1'b0;
            exp_held = 1'b0; exp_code = 5'd0;
        end else begin
            cyc++;
            s = (key_code >= 5'd1 && key_code <= 5'd16) ? key_code : 5'd0;
            exp_valid = 1'b0; exp_repeat = 1'b0; exp_release = 1'b0;
            if (!m_held) begin
                if (s == 5'd0) m_run = 0;
                else if (s == m_key && m_run > 0) m_run++;
                else begin m_key = s; m_run = 1; end
                if (m_run == D) begin
                    exp_valid = 1'b1; exp_code = s;
                    m_held = 1'b1; m_since = 0; m_nrep = 0; m_off = 0; m_run = 0;
                    q_cyc.push_back(cyc); q_kind.push_back(K_PRESS); q_code.push_back(s);
                end
            end else if (s == m_key) begin
                if (m_off > 0) begin
                    m_off = 0; m_since = 0; m_nrep = 0;
                end else begin
                    m_since++;
                    if (m_since == ((m_nrep == 0) ? RD : RP)) begin
                        exp_valid = 1'b1; exp_repeat = 1'b1; exp_code = m_key;
                        m_since = 0; m_nrep++;
                        q_cyc.push_back(cyc); q_kind.push_back(K_REP); q_code.push_back(m_key);
                    end
                end
            end else begin
                m_off++;
                if (m_off == D) begin
                    exp_release = 1'b1; exp_code = m_key;
                    m_held = 1'b0; m_run = 0; m_off = 0;
                    q_cyc.push_back(cyc); q_kind.push_back(K_REL); q_code.push_back(m_key);
                end
            end
            exp_held = m_held;
        end
    end

    int errors = 0;
    int checks = 0;
    int n_valid = 0;
    int n_rel = 0;
    int held_seen = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_cycle();
        if (!rst) begin
            check("ev_valid",   int'(ev_valid),   int'(exp_valid));
            check("ev_repeat",  int'(ev_repeat),  int'(exp_repeat));
            check("ev_release", int'(ev_release), int'(exp_release));
            check("ev_code",    int'(ev_code),    int'(exp_code));
            check("held",       int'(held),       int'(exp_held));
            n_valid += int'(ev_valid);
            n_rel   += int'(ev_release);
            if (held) held_seen++;
        end
    endtask

    task automatic drive(input logic [4:0] k, input int n);
        for (int i = 0; i < n; i++) begin
            key_code = k;
            @(negedge mclk);
            cmp_cycle();
        end
    endtask

    task automatic check_ev(input string name, input int idx, input int kind,
                            input int ref_cyc, input int ofs, input int code);
        if (idx < q_kind.size()) begin
            check({name, "_kind"}, q_kind[idx], kind);
            check({name, "_ofs"},  q_cyc[idx] - ref_cyc, ofs);
            check({name, "_code"}, int'(q_code[idx]), code);
        end else begin
            check({name, "_missing"}, q_kind.size(), idx + 1);
        end
    endtask

    function automatic int ev_cyc(input int idx);
        return (idx < q_cyc.size()) ? q_cyc[idx] : -1000;
    endfunction

    int b, c, c2, d, v0, r0, h0;

    initial begin
        rst = 1'b1;
        key_code = 5'd0;
        repeat (3) @(negedge mclk);
        check("rst_valid",   int'(ev_valid),   0);
        check("rst_repeat",  int'(ev_repeat),  0);
        check("rst_release", int'(ev_release), 0);
        check("rst_code",    int'(ev_code),    0);
        check("rst_held",    int'(held),       0);
        rst = 1'b0;
        drive(5'd0, 3);

        // Clean press of key 7
        b = q_kind.size(); v0 = n_valid; r0 = n_rel;
        c = cyc; drive(5'd7, 30);
        d = cyc; drive(5'd0, 8);
        check("cp_events", q_kind.size() - b, 8);
        check_ev("cp_press", b, K_PRESS, c, 4, 7);
        for (int i = 0; i < 6; i++)
            check_ev($sformatf("cp_rep%0d", i), b + 1 + i, K_REP, ev_cyc(b), 10 + 3 * i, 7);
        check_ev("cp_rel", b + 7, K_REL, d, 4, 7);
        check("cp_dut_valid", n_valid - v0, 7);
        check("cp_dut_rel",   n_rel - r0, 1);

        // Bounce never reaches four stable samples
        b = q_kind.size(); v0 = n_valid; r0 = n_rel; h0 = held_seen;
        drive(5'd3, 2); drive(5'd0, 1); drive(5'd3, 2); drive(5'd0, 10);
        check("bn_events",    q_kind.size() - b, 0);
        check("bn_dut_valid", n_valid - v0, 0);
        check("bn_dut_rel",   n_rel - r0, 0);
        check("bn_dut_held",  held_seen - h0, 0);

        // Key change 5 -> 9: release of 5 precedes the press of 9
        b = q_kind.size(); v0 = n_valid; r0 = n_rel;
        c = cyc; drive(5'd5, 8);
        c2 = cyc; drive(5'd9, 20);
        d = cyc; drive(5'd0, 8);
        check("kc_events", q_kind.size() - b, 5);
        check_ev("kc_press5", b,     K_PRESS, c,  4, 5);
        check_ev("kc_rel5",   b + 1, K_REL,   c2, 4, 5);
        check_ev("kc_press9", b + 2, K_PRESS, ev_cyc(b + 1), 4, 9);
        check_ev("kc_rep9",   b + 3, K_REP,   ev_cyc(b + 2), 10, 9);
        check_ev("kc_rel9",   b + 4, K_REL,   d, 4, 9);
        check("kc_dut_valid", n_valid - v0, 3);
        check("kc_dut_rel",   n_rel - r0, 2);

        // Release glitch of two cycles restarts the repeat delay
        b = q_kind.size(); v0 = n_valid; r0 = n_rel;
        c = cyc; drive(5'd2, 8); drive(5'd0, 2);
        c2 = cyc; drive(5'd2, 15);
        d = cyc; drive(5'd0, 8);
        check("gl_events", q_kind.size() - b, 4);
        check_ev("gl_press", b,     K_PRESS, c,  4, 2);
        check_ev("gl_rep1",  b + 1, K_REP,   c2, 11, 2);
        check_ev("gl_rep2",  b + 2, K_REP,   ev_cyc(b + 1), 3, 2);
        check_ev("gl_rel",   b + 3, K_REL,   d, 4, 2);
        check("gl_dut_valid", n_valid - v0, 3);
        check("gl_dut_rel",   n_rel - r0, 1);

        // Out-of-range codes behave as no key
        b = q_kind.size(); v0 = n_valid; r0 = n_rel; h0 = held_seen;
        drive(5'd20, 10); drive(5'd17, 3); drive(5'd31, 3); drive(5'd0, 2);
        check("iv_events",    q_kind.size() - b, 0);
        check("iv_dut_valid", n_valid - v0, 0);
        check("iv_dut_rel",   n_rel - r0, 0);
        check("iv_dut_held",  held_seen - h0, 0);

        // Asynchronous reset while auto-repeating key 11
        drive(5'd11, 20);
        check("rh_held_before", int'(held), 1);
        check("rh_code_before", int'(ev_code), 11);
        #2 rst = 1'b1;
        #1;
        check("rh_valid",   int'(ev_valid),   0);
        check("rh_repeat",  int'(ev_repeat),  0);
        check("rh_release", int'(ev_release), 0);
        check("rh_code",    int'(ev_code),    0);
        check("rh_held",    int'(held),       0);
        @(negedge mclk);
        @(negedge mclk);
        b = q_kind.size(); v0 = n_valid; r0 = n_rel;
        c = cyc;
        rst = 1'b0;
        drive(5'd11, 8);
        check_ev("rh_press", b, K_PRESS, c, 4, 11);
        check("rh_dut_valid", n_valid - v0, 1);
        check("rh_dut_rel",   n_rel - r0, 0);
        drive(5'd0, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
